// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: datapath width, writeback source
// select and load funct3 values.
package mem_wb_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_RSV = 2'd3
  } result_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load data extraction: selects byte/halfword lanes from an
// aligned word and sign- or zero-extends them.
module load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{addr_lo_i, 3'b000} +: 8];
    half_v = word_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      // LW and the undefined encodings pass the word through
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, writeback mux, register
// file write port (also the WB->EX forwarding source) and retire counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_result_sel,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_count
);

  logic             valid_q, valid_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [XLEN-1:0]  alu_q, alu_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  load_data;
  logic             capture;

  assign capture = ~flush & ~stall;

  always_comb begin
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    alu_d       = alu_q;
    pc4_d       = pc4_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    count_d     = count_q;
    if (capture) begin
      reg_write_d = in_reg_write;
      rd_d        = in_rd;
      sel_d       = in_result_sel;
      funct3_d    = in_funct3;
      addr_lo_d   = in_addr_lo;
      alu_d       = in_alu_result;
      pc4_d       = in_pc_plus4;
      rdata_d     = in_mem_rdata;
      valid_d     = in_valid;
      if (valid_q) count_d = count_q + CNT_W'(1);
    end else if (flush) begin
      // flush beats stall: entry dropped without retiring
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      sel_q       <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      rdata_q     <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      alu_q       <= alu_d;
      pc4_q       <= pc4_d;
      rdata_q     <= rdata_d;
      count_q     <= count_d;
    end
  end

  load_extend u_load_extend (
    .word_i    (rdata_q),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  always_comb begin
    case (result_sel_e'(sel_q))
      RES_MEM: rf_wd = load_data;
      RES_PC4: rf_wd = pc4_q;
      default: rf_wd = alu_q;
    endcase
  end

  // stalled cycles suppress the write so each instruction commits once
  assign rf_we        = valid_q & reg_write_q & (|rd_q) & ~stall;
  assign rf_wa        = rd_q;
  assign wb_valid     = valid_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected register-file
// writes, a negedge monitor pops and compares them.
module tb_mem_wb_stage;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, in_reg_write = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [1:0]    in_result_sel = '0;
  logic [2:0]    in_funct3 = '0;
  logic [1:0]    in_addr_lo = '0;
  logic [31:0]   in_alu_result = '0, in_pc_plus4 = '0, in_mem_rdata = '0;
  logic          rf_we, wb_valid;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic [CW-1:0] retire_count;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_result_sel(in_result_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_mem_rdata(in_mem_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .wb_valid(wb_valid),
    .retire_count(retire_count)
  );

  typedef struct {
    bit st, fl, v, rw;
    bit [4:0] rd; bit [1:0] sel; bit [2:0] f3; bit [1:0] alo;
    bit [31:0] alu, pc4, rdata;
  } stim_t;

  typedef struct { bit [4:0] wa; bit [31:0] wd; } wr_t;

  wr_t q[$];
  int  n_checks = 0, n_fail = 0;
  bit  mon_en = 0;
  bit  m_valid = 0, m_writes = 0, m_written = 0;
  int  m_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [1:0] alo, input bit [31:0] w);
    bit [31:0] b, h;
    b = (w >> (8 * alo)) & 32'hFF;
    h = (w >> (alo[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit [31:0] ref_wd(input stim_t s);
    if (s.sel == 2'd1) return ref_load(s.f3, s.alo, s.rdata);
    if (s.sel == 2'd2) return s.pc4;
    return s.alu;
  endfunction

  function automatic stim_t instr(input bit [4:0] rd, input bit [1:0] sel, input bit [2:0] f3,
                                  input bit [1:0] alo, input bit [31:0] alu,
                                  input bit [31:0] pc4, input bit [31:0] rdata);
    stim_t s;
    s = '{default: 0};
    s.v = 1; s.rw = 1; s.rd = rd; s.sel = sel; s.f3 = f3; s.alo = alo;
    s.alu = alu; s.pc4 = pc4; s.rdata = rdata;
    return s;
  endfunction

  // One cycle: drive inputs, advance the reference at the edge
  task automatic step(input stim_t s);
    stall = s.st; flush = s.fl; in_valid = s.v; in_reg_write = s.rw; in_rd = s.rd;
    in_result_sel = s.sel; in_funct3 = s.f3; in_addr_lo = s.alo;
    in_alu_result = s.alu; in_pc_plus4 = s.pc4; in_mem_rdata = s.rdata;
    @(posedge clk);
    if (m_valid && !s.st && !s.fl) m_count = (m_count + 1) % (1 << CW);
    if (s.fl) begin
      if (m_valid && m_writes && !m_written) void'(q.pop_back());
      m_valid = 0;
    end else if (!s.st) begin
      m_valid = s.v; m_writes = s.v && s.rw && (s.rd != 0); m_written = 0;
      if (m_writes) q.push_back('{wa: s.rd, wd: ref_wd(s)});
    end
    #1;
  endtask

  task automatic idle(input bit st, input bit fl);
    stim_t s;
    s = '{default: 0};
    s.st = st; s.fl = fl;
    step(s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we", rf_we, 0); chk("rst_valid", wb_valid, 0);
    chk("rst_count", retire_count, 0); chk("rst_wa", rf_wa, 0); chk("rst_wd", rf_wd, 0);
    m_valid = 0; m_writes = 0; m_written = 0; m_count = 0; q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("mon_we", rf_we, m_valid && m_writes && !m_written && !stall);
      chk("mon_valid", wb_valid, m_valid);
      chk("mon_count", retire_count, m_count);
      if (rf_we) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got wa=%0d wd=%0h expected no write", rf_wa, rf_wd);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_wa", rf_wa, e.wa);
          chk("wr_wd", rf_wd, e.wd);
          m_written = 1;
        end
      end
    end
  end

  localparam bit [31:0] LW_WORD = 32'h80FF_7F01;

  initial begin
    stim_t s;
    bit [2:0]  lf3 [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    bit [1:0]  lalo[6] = '{2'd1,   2'd2,   2'd3,   2'd2,   2'd0,   2'd0};
    bit [31:0] lexp[6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                           32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", wb_valid, 0); chk("init_we", rf_we, 0); chk("init_count", retire_count, 0);
    rst = 1'b0;
    mon_en = 1;

    step(instr(5'd3, 2'd0, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 32'h0));
    chk("alu_we", rf_we, 1); chk("alu_wa", rf_wa, 3); chk("alu_wd", rf_wd, 32'h0000_1234);
    idle(0, 0);
    chk("alu_count", retire_count, 1);

    for (int i = 0; i < 6; i++) begin
      step(instr(5'd7, 2'd1, lf3[i], lalo[i], 32'hDEAD_BEEF, 32'h0, LW_WORD));
      chk($sformatf("load%0d_wd", i), rf_wd, lexp[i]);
    end

    step(instr(5'd0, 2'd0, 3'b000, 2'd0, 32'h55, 32'h0, 32'h0));
    chk("x0_we", rf_we, 0);
    step(instr(5'd1, 2'd2, 3'b000, 2'd0, 32'h99, 32'h0000_0104, 32'h0));
    chk("jal_we", rf_we, 1); chk("jal_wd", rf_wd, 32'h0000_0104);

    step(instr(5'd9, 2'd0, 3'b000, 2'd0, 32'hCAFE_0009, 32'h0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      s = instr(5'd12, 2'd0, 3'b000, 2'd0, 32'h1111_1111, 32'h0, 32'h0);
      s.st = 1;
      step(s);
      chk("stall_we", rf_we, 0); chk("stall_wa", rf_wa, 9); chk("stall_wd", rf_wd, 32'hCAFE_0009);
    end
    idle(0, 0);

    s = instr(5'd6, 2'd0, 3'b000, 2'd0, 32'h66, 32'h0, 32'h0);
    s.fl = 1;
    step(s);
    chk("flush_valid", wb_valid, 0); chk("flush_we", rf_we, 0);
    idle(0, 0);

    step(instr(5'd4, 2'd0, 3'b000, 2'd0, 32'h44, 32'h0, 32'h0));
    idle(1, 1);
    chk("stflush_valid", wb_valid, 0);
    idle(0, 0);

    step(instr(5'd5, 2'd0, 3'b000, 2'd0, 32'h5555, 32'h0, 32'h0));
    chk("pre_rst_valid", wb_valid, 1);
    do_reset();

    for (int i = 0; i < 17; i++)
      step(instr(5'($urandom_range(31)), 2'd0, 3'b000, 2'd0, $urandom, 32'h0, 32'h0));
    idle(0, 0);
    chk("wrap_count", retire_count, 1);

    for (int i = 0; i < 400; i++) begin
      s.st = ($urandom_range(99) < 20); s.fl = ($urandom_range(99) < 8);
      s.v = ($urandom_range(99) < 80); s.rw = ($urandom_range(99) < 75);
      s.rd = 5'($urandom_range(31)); s.sel = 2'($urandom_range(3));
      s.f3 = 3'($urandom_range(7)); s.alo = 2'($urandom_range(3));
      s.alu = $urandom; s.pc4 = $urandom; s.rdata = $urandom;
      step(s);
    end
    repeat (3) idle(0, 0);
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
